proj_kmer_stream: RTL and testbench

//  Streaming k-mer extractor with valid/ready handshakes on both sides. Emits one k-mer per

---
 rtl/proj_pkg.sv | 20 ++
 rtl/proj_kmer_canon_sel.sv | 22 ++
 rtl/proj_kmer_stream.sv | 134 +++++++++++++
 tb/tb_proj_kmer_stream.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared nucleotide encodings and k-mer types for the k-mer streaming front end.
// Complementing a 2-bit base is a bitwise NOT (A<->T, C<->G).
package proj_pkg;

   localparam int PKG_DATA_BITS = 2;
   localparam int PKG_KMER_LEN  = 16;

   typedef logic [PKG_DATA_BITS-1:0]                    base_t;
   typedef logic [PKG_KMER_LEN-1:0][PKG_DATA_BITS-1:0]  kmer_t;

   localparam base_t BASE_A = 2'd0;
   localparam base_t BASE_C = 2'd1;
   localparam base_t BASE_G = 2'd2;
   localparam base_t BASE_T = 2'd3;

   function automatic base_t comp_base(input base_t b);
      return ~b;
   endfunction

endpackage

// File: rtl/proj_kmer_canon_sel.sv
// Canonical k-mer selection: picks the numerically smaller of forward and
// reverse-complement windows; ties keep the forward strand.
module proj_kmer_canon_sel #(
   parameter int DATA_BITS = 2,
   parameter int KMER_LEN  = 16,
   parameter int CANONICAL = 1
) (
   input  logic [KMER_LEN-1:0][DATA_BITS-1:0] i_fwd,
   input  logic [KMER_LEN-1:0][DATA_BITS-1:0] i_rc,
   output logic [KMER_LEN-1:0][DATA_BITS-1:0] o_kmer,
   output logic                               o_is_rc
);

   logic w_use_rc;

   always_comb begin
      w_use_rc = (CANONICAL != 0) && (i_rc < i_fwd);
      o_kmer   = w_use_rc ? i_rc : i_fwd;
      o_is_rc  = w_use_rc;
   end

endmodule

// File: rtl/proj_kmer_stream.sv
// Streaming k-mer extractor: slides forward and reverse-complement windows over
// accepted bases and emits one (optionally canonical) k-mer per full window.
module proj_kmer_stream
   import proj_pkg::*;
#(
   parameter int DATA_BITS = 2,
   parameter int KMER_LEN  = 16,
   parameter int CANONICAL = 1,
   parameter int POS_W     = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start_over,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [DATA_BITS-1:0]               in_data,
   input  logic                               in_n,
   input  logic                               in_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [KMER_LEN-1:0][DATA_BITS-1:0] out_kmer,
   output logic                               out_is_rc,
   output logic [POS_W-1:0]                   out_pos,
   output logic                               out_last,
   output logic                               short_seq
);

   localparam int                CNT_W    = $clog2(KMER_LEN + 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(KMER_LEN);
   localparam logic [POS_W-1:0]  POS_BACK = POS_W'(KMER_LEN - 1);

   logic [KMER_LEN-1:0][DATA_BITS-1:0] r_fwd, r_rc;
   logic [CNT_W-1:0]                   r_cnt;
   logic [POS_W-1:0]                   r_pos;
   logic                               r_seen;
   logic                               r_out_valid;
   logic [KMER_LEN-1:0][DATA_BITS-1:0] r_out_kmer;
   logic                               r_out_is_rc;
   logic [POS_W-1:0]                   r_out_pos;
   logic                               r_out_last;
   logic                               r_short;

   logic                               w_in_ready;
   logic                               w_accept;
   logic                               w_emit;
   logic [CNT_W-1:0]                   w_cnt_nxt;
   logic [KMER_LEN-1:0][DATA_BITS-1:0] w_fwd_nxt, w_rc_nxt, w_sel_kmer;
   logic                               w_sel_is_rc;

   always_comb begin
      w_in_ready = ~start_over & (~r_out_valid | out_ready);
      w_accept   = in_valid & w_in_ready;
      w_fwd_nxt  = {r_fwd[KMER_LEN-2:0], in_data};
      w_rc_nxt   = {~in_data, r_rc[KMER_LEN-1:1]};
      // An ambiguous base breaks the run; a full window stays full while bases keep coming.
      if (in_n)
         w_cnt_nxt = '0;
      else if (r_cnt == CNT_FULL)
         w_cnt_nxt = CNT_FULL;
      else
         w_cnt_nxt = r_cnt + CNT_W'(1);
      w_emit = w_accept & (w_cnt_nxt == CNT_FULL);
   end

   proj_kmer_canon_sel #(
      .DATA_BITS (DATA_BITS),
      .KMER_LEN  (KMER_LEN),
      .CANONICAL (CANONICAL)
   ) u_canon_sel (
      .i_fwd   (w_fwd_nxt),
      .i_rc    (w_rc_nxt),
      .o_kmer  (w_sel_kmer),
      .o_is_rc (w_sel_is_rc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fwd       <= '0;
         r_rc        <= '0;
         r_cnt       <= '0;
         r_pos       <= '0;
         r_seen      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_kmer  <= '0;
         r_out_is_rc <= 1'b0;
         r_out_pos   <= '0;
         r_out_last  <= 1'b0;
         r_short     <= 1'b0;
      end else if (start_over) begin
         r_fwd       <= '0;
         r_rc        <= '0;
         r_cnt       <= '0;
         r_pos       <= '0;
         r_seen      <= 1'b0;
         r_out_valid <= 1'b0;
         r_short     <= 1'b0;
      end else begin
         r_short <= 1'b0;
         if (w_accept) begin
            r_fwd <= w_fwd_nxt;
            r_rc  <= w_rc_nxt;
            if (in_last) begin
               r_cnt   <= '0;
               r_pos   <= '0;
               r_seen  <= 1'b0;
               r_short <= ~(r_seen | w_emit);
            end else begin
               r_cnt  <= w_cnt_nxt;
               r_pos  <= r_pos + POS_W'(1);
               r_seen <= r_seen | w_emit;
            end
         end
         // Output holds until taken; a same-cycle emit replaces it for full throughput.
         if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_kmer  <= w_sel_kmer;
            r_out_is_rc <= w_sel_is_rc;
            r_out_pos   <= r_pos - POS_BACK;
            r_out_last  <= in_last;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_kmer  = r_out_kmer;
   assign out_is_rc = r_out_is_rc;
   assign out_pos   = r_out_pos;
   assign out_last  = r_out_last;
   assign short_seq = r_short;

endmodule

// File: tb/tb_proj_kmer_stream.sv
// Directed bench for proj_kmer_stream with KMER_LEN=4; one forward-only and one
// canonical instance share the same input stream.
module tb_proj_kmer_stream;
   import proj_pkg::*;

   localparam int K = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_over = 1'b0;
   logic in_valid = 1'b0;
   logic [1:0] in_data = 2'd0;
   logic in_n = 1'b0;
   logic in_last = 1'b0;
   logic out_ready = 1'b1;

   logic o0_ready, o0_valid, o0_is_rc, o0_last, o0_short;
   logic [K-1:0][1:0] o0_kmer;
   logic [31:0] o0_pos;
   logic o1_ready, o1_valid, o1_is_rc, o1_last, o1_short;
   logic [K-1:0][1:0] o1_kmer;
   logic [31:0] o1_pos;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   proj_kmer_stream #(.DATA_BITS(2), .KMER_LEN(K), .CANONICAL(0), .POS_W(32)) dut0 (
      .clk(clk), .rst(rst), .start_over(start_over), .in_valid(in_valid), .in_ready(o0_ready),
      .in_data(in_data), .in_n(in_n), .in_last(in_last), .out_valid(o0_valid),
      .out_ready(out_ready), .out_kmer(o0_kmer), .out_is_rc(o0_is_rc), .out_pos(o0_pos),
      .out_last(o0_last), .short_seq(o0_short));

   proj_kmer_stream #(.DATA_BITS(2), .KMER_LEN(K), .CANONICAL(1), .POS_W(32)) dut1 (
      .clk(clk), .rst(rst), .start_over(start_over), .in_valid(in_valid), .in_ready(o1_ready),
      .in_data(in_data), .in_n(in_n), .in_last(in_last), .out_valid(o1_valid),
      .out_ready(out_ready), .out_kmer(o1_kmer), .out_is_rc(o1_is_rc), .out_pos(o1_pos),
      .out_last(o1_last), .short_seq(o1_short));

   task automatic push(input logic [1:0] d, input logic n, input logic last);
      in_valid = 1'b1; in_data = d; in_n = n; in_last = last;
      @(posedge clk); #1;
      in_valid = 1'b0; in_n = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o0_valid); end
      checks++; if (o0_kmer !== 8'h00) begin errors++; $display("FAIL reset_kmer got %h want 00", o0_kmer); end
      checks++; if (o0_pos !== 32'd0) begin errors++; $display("FAIL reset_pos got %0d want 0", o0_pos); end
      checks++; if ({o0_is_rc, o0_last, o0_short} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {o0_is_rc, o0_last, o0_short}); end
      checks++; if (o0_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", o0_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_forward();
      push(BASE_A, 0, 0);
      push(BASE_C, 0, 0);
      push(BASE_G, 0, 0);
      checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL fwd_early_valid got %0b want 0", o0_valid); end
      push(BASE_T, 0, 0);
      checks++; if (o0_valid !== 1'b1 || o0_kmer !== 8'h1B || o0_pos !== 32'd0) begin errors++; $display("FAIL fwd_kmer0 got v=%0b k=%h p=%0d want v=1 k=1b p=0", o0_valid, o0_kmer, o0_pos); end
      checks++; if (o1_kmer !== 8'h1B || o1_is_rc !== 1'b0) begin errors++; $display("FAIL canon_palindrome got k=%h rc=%0b want k=1b rc=0", o1_kmer, o1_is_rc); end
      push(BASE_A, 0, 1);
      checks++; if (o0_valid !== 1'b1 || o0_kmer !== 8'h6C || o0_pos !== 32'd1 || o0_last !== 1'b1) begin errors++; $display("FAIL fwd_kmer1 got v=%0b k=%h p=%0d l=%0b want v=1 k=6c p=1 l=1", o0_valid, o0_kmer, o0_pos, o0_last); end
      checks++; if (o1_kmer !== 8'h6C || o1_is_rc !== 1'b0) begin errors++; $display("FAIL canon_fwd_smaller got k=%h rc=%0b want k=6c rc=0", o1_kmer, o1_is_rc); end
      checks++; if (o0_short !== 1'b0) begin errors++; $display("FAIL fwd_no_short got %0b want 0", o0_short); end
      @(posedge clk); #1;
      checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain got %0b want 0", o0_valid); end
   endtask

   task automatic test_canonical();
      for (int i = 0; i < 4; i++) push(BASE_T, 0, i == 3);
      checks++; if (o1_valid !== 1'b1 || o1_kmer !== 8'h00 || o1_is_rc !== 1'b1) begin errors++; $display("FAIL canon_tttt got v=%0b k=%h rc=%0b want v=1 k=00 rc=1", o1_valid, o1_kmer, o1_is_rc); end
      checks++; if (o0_kmer !== 8'hFF || o0_is_rc !== 1'b0) begin errors++; $display("FAIL fwdonly_tttt got k=%h rc=%0b want k=ff rc=0", o0_kmer, o0_is_rc); end
      push(BASE_A, 0, 0);
      push(BASE_C, 0, 0);
      push(BASE_G, 0, 0);
      push(BASE_T, 0, 1);
      checks++; if (o1_valid !== 1'b1 || o1_kmer !== 8'h1B || o1_is_rc !== 1'b0 || o1_pos !== 32'd0) begin errors++; $display("FAIL canon_acgt got v=%0b k=%h rc=%0b p=%0d want v=1 k=1b rc=0 p=0", o1_valid, o1_kmer, o1_is_rc, o1_pos); end
      @(posedge clk); #1;
   endtask

   task automatic test_ambiguous();
      logic [1:0] seq [7];
      logic       nb  [7];
      int emits;
      seq = '{BASE_A, BASE_C, BASE_A, BASE_G, BASE_T, BASE_A, BASE_C};
      nb  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      emits = 0;
      for (int i = 0; i < 7; i++) begin
         push(seq[i], nb[i], i == 6);
         if (o0_valid === 1'b1) emits++;
      end
      checks++; if (emits !== 1) begin errors++; $display("FAIL n_emit_count got %0d want 1", emits); end
      checks++; if (o0_kmer !== 8'hB1 || o0_pos !== 32'd3 || o0_last !== 1'b1) begin errors++; $display("FAIL n_kmer got k=%h p=%0d l=%0b want k=b1 p=3 l=1", o0_kmer, o0_pos, o0_last); end
      emits = 0;
      push(BASE_G, 0, 0); if (o0_valid === 1'b1) emits++;
      push(BASE_G, 1, 0); if (o0_valid === 1'b1) emits++;
      push(BASE_G, 1, 0); if (o0_valid === 1'b1) emits++;
      push(BASE_G, 1, 1); if (o0_valid === 1'b1) emits++;
      checks++; if (emits !== 0) begin errors++; $display("FAIL nn_emit_count got %0d want 0", emits); end
      checks++; if (o0_short !== 1'b1) begin errors++; $display("FAIL nn_short got %0b want 1", o0_short); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      push(BASE_A, 0, 0);
      push(BASE_C, 0, 0);
      push(BASE_G, 0, 0);
      push(BASE_T, 0, 0);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = BASE_A;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (o0_valid !== 1'b1 || o0_kmer !== 8'h1B || o0_pos !== 32'd0 || o0_last !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v=%0b k=%h p=%0d want v=1 k=1b p=0", i, o0_valid, o0_kmer, o0_pos); end
         checks++; if (o0_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %0b want 0", i, o0_ready); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (o0_valid !== 1'b1 || o0_kmer !== 8'h6C || o0_pos !== 32'd1) begin errors++; $display("FAIL bp_release got v=%0b k=%h p=%0d want v=1 k=6c p=1", o0_valid, o0_kmer, o0_pos); end
      push(BASE_G, 0, 1);
      checks++; if (o0_valid !== 1'b1 || o0_kmer !== 8'hB2 || o0_pos !== 32'd2 || o0_last !== 1'b1) begin errors++; $display("FAIL bp_next got v=%0b k=%h p=%0d l=%0b want v=1 k=b2 p=2 l=1", o0_valid, o0_kmer, o0_pos, o0_last); end
      @(posedge clk); #1;
      checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", o0_valid); end
   endtask

   task automatic test_short_and_start_over();
      push(BASE_A, 0, 0);
      push(BASE_C, 0, 0);
      push(BASE_G, 0, 1);
      checks++; if (o0_short !== 1'b1 || o0_valid !== 1'b0) begin errors++; $display("FAIL short_pulse got s=%0b v=%0b want s=1 v=0", o0_short, o0_valid); end
      @(posedge clk); #1;
      checks++; if (o0_short !== 1'b0) begin errors++; $display("FAIL short_one_cycle got %0b want 0", o0_short); end
      push(BASE_A, 0, 0);
      push(BASE_C, 0, 0);
      push(BASE_G, 0, 0);
      push(BASE_T, 0, 0);
      checks++; if (o0_valid !== 1'b1 || o0_kmer !== 8'h1B || o0_pos !== 32'd0) begin errors++; $display("FAIL short_next_seq got v=%0b k=%h p=%0d want v=1 k=1b p=0", o0_valid, o0_kmer, o0_pos); end
      out_ready = 1'b0;
      start_over = 1'b1;
      #1;
      checks++; if (o0_ready !== 1'b0) begin errors++; $display("FAIL so_in_ready got %0b want 0", o0_ready); end
      @(posedge clk); #1;
      start_over = 1'b0;
      out_ready = 1'b1;
      checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL so_discard got %0b want 0", o0_valid); end
      push(BASE_A, 0, 0);
      push(BASE_C, 0, 0);
      push(BASE_G, 0, 0);
      checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL so_refill got %0b want 0", o0_valid); end
      push(BASE_T, 0, 0);
      checks++; if (o0_valid !== 1'b1 || o0_kmer !== 8'h1B || o0_pos !== 32'd0) begin errors++; $display("FAIL so_restart got v=%0b k=%h p=%0d want v=1 k=1b p=0", o0_valid, o0_kmer, o0_pos); end
      push(BASE_A, 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_stream();
      push(BASE_C, 0, 0);
      push(BASE_C, 0, 0);
      push(BASE_C, 0, 0);
      push(BASE_C, 0, 0);
      out_ready = 1'b0;
      checks++; if (o0_valid !== 1'b1 || o0_kmer !== 8'h55) begin errors++; $display("FAIL rst_pre got v=%0b k=%h want v=1 k=55", o0_valid, o0_kmer); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (o0_valid !== 1'b0 || o0_ready !== 1'b1) begin errors++; $display("FAIL rst_mid got v=%0b rdy=%0b want v=0 rdy=1", o0_valid, o0_ready); end
      rst = 1'b0;
      out_ready = 1'b1;
      push(BASE_C, 0, 0);
      push(BASE_C, 0, 0);
      push(BASE_C, 0, 0);
      checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL rst_refill got %0b want 0", o0_valid); end
      push(BASE_C, 0, 1);
      checks++; if (o0_valid !== 1'b1 || o0_pos !== 32'd0 || o0_kmer !== 8'h55) begin errors++; $display("FAIL rst_restart got v=%0b k=%h p=%0d want v=1 k=55 p=0", o0_valid, o0_kmer, o0_pos); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_canonical();
      test_ambiguous();
      test_backpressure();
      test_short_and_start_over();
      test_reset_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without completing");
      $fatal(1);
   end

endmodule
